multiword_add_sequencer: RTL and testbench

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

---
 rtl/multiword_add_sequencer_pkg.sv | 16 +
 rtl/multiword_add_sequencer_ling_adder.sv | 43 ++++
 rtl/multiword_add_sequencer.sv | 122 ++++++++++++
 tb/tb_multiword_add_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and constants for the multiword add sequencer.
package mas_pkg;

  localparam int LIMB_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int idx_w(input int limbs);
    return (limbs > 1) ? $clog2(limbs) : 1;
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_ling_adder.sv
// 64-bit Ling adder: Ling pseudo-carries resolved by a parallel-prefix tree,
// real carries recovered as t[i-1] & h[i].
module _64_bit_hierarchical_Ling_adder
  import mas_pkg::*;
(
  input  logic [LIMB_W-1:0] a_i,
  input  logic [LIMB_W-1:0] b_i,
  input  logic              c_i,
  output logic [LIMB_W-1:0] sum_o,
  output logic              c_o
);

  logic [LIMB_W-1:0] g, t, x;
  logic [LIMB_W:0]   hg, hp, ng, np, c;

  assign g = a_i & b_i;
  assign t = a_i | b_i;
  assign x = a_i ^ b_i;

  // Element 0 carries cin (P=0); element j>=1 is (g[j-1], t[j-2]) with t[-1]=1,
  // so the prefix over 0..j yields the pseudo-carry h[j] directly.
  always_comb begin
    hg = {g, c_i};
    hp = {t[LIMB_W-2:0], 1'b1, 1'b0};
    ng = '0;
    np = '0;
    for (int d = 1; d <= LIMB_W; d = d * 2) begin
      ng = hg;
      np = hp;
      for (int j = d; j <= LIMB_W; j++) begin
        ng[j] = hg[j] | (hp[j] & hg[j-d]);
        np[j] = hp[j] & hp[j-d];
      end
      hg = ng;
      hp = np;
    end
  end

  assign c     = {t & hg[LIMB_W:1], c_i};
  assign sum_o = x ^ c[LIMB_W-1:0];
  assign c_o   = c[LIMB_W];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-limb add/subtract: one 64-bit limb per cycle through a single shared adder.
//   state   | meaning
//   IDLE    | waiting for a request, in_ready=1
//   RUN     | one limb per edge, idx counts limbs
//   DONE    | result held until out_ready
module multiword_add_sequencer
  import mas_pkg::*;
#(
  parameter int LIMBS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LIMB_W*LIMBS-1:0] a,
  input  logic [LIMB_W*LIMBS-1:0] b,
  input  logic                    cin,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LIMB_W*LIMBS-1:0] sum,
  output logic                    cout
);

  localparam int W     = LIMB_W * LIMBS;
  localparam int IDX_W = idx_w(LIMBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             sub_q, sub_d, carry_q, carry_d, cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [LIMB_W-1:0] a_limb, b_limb, add_sum;
  logic              add_co;

  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int i = 0; i < LIMBS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_limb = a_q[i*LIMB_W +: LIMB_W];
        b_limb = b_q[i*LIMB_W +: LIMB_W];
      end
    end
  end

  // Subtraction is A + ~B + 1; the +1 enters through the carry seeded at accept.
  _64_bit_hierarchical_Ling_adder u_adder (
    .a_i  (a_limb),
    .b_i  (b_limb ^ {LIMB_W{sub_q}}),
    .c_i  (carry_q),
    .sum_o(add_sum),
    .c_o  (add_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub | cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < LIMBS; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*LIMB_W +: LIMB_W] = add_sum;
        end
        carry_d = add_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Randomized bench for multiword_add_sequencer against a wide-arithmetic reference.
module tb_multiword_add_sequencer;

  localparam int LIMBS = 4;
  localparam int W     = 64 * LIMBS;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.LIMBS(LIMBS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
  );

  task automatic chk(input string name, input logic [W:0] got, input logic [W:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // {cout, sum}: plain wide arithmetic; for subtraction cout means A >= B
  function automatic logic [W:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rc, input logic rs);
    logic [W:0] r;
    if (rs) begin
      r[W-1:0] = ra - rb;
      r[W]     = (ra >= rb);
    end else begin
      r = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
    end
    return r;
  endfunction

  // Behavioural model: accept in idle, result appears LIMBS edges later, held until out_ready.
  int         m_mode  = 0;   // 0 idle, 1 busy, 2 done
  int         m_cnt   = 0;
  logic [W:0] m_pend  = '0;
  logic [W:0] m_exp   = '0;
  bit         m_known = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      m_mode  = 0;
      m_exp   = '0;
      m_known = 1'b1;
      chk("reset_in_ready", {{W{1'b0}}, in_ready}, 1);
      chk("reset_out_valid", {{W{1'b0}}, out_valid}, 0);
      chk("reset_result", {cout, sum}, 0);
    end else begin
      chk("in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, m_mode == 0});
      chk("out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, m_mode == 2});
      if (m_known) chk("result", {cout, sum}, m_exp);
      case (m_mode)
        0: if (in_valid) begin
          m_pend  = ref_result(a, b, cin, sub);
          m_mode  = 1;
          m_cnt   = LIMBS;
          m_known = 1'b0;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_mode  = 2;
            m_exp   = m_pend;
            m_known = 1'b1;
          end
        end
        default: if (out_ready) m_mode = 0;
      endcase
    end
  end

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0]  v;
    logic [63:0]   l;
    v = '0;
    for (int i = 0; i < LIMBS; i++) begin
      case ($urandom_range(0, 3))
        0:       l = '0;
        1:       l = '1;
        default: l = {$urandom, $urandom};
      endcase
      v[i*64 +: 64] = l;
    end
    return v;
  endfunction

  task automatic run_req(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rc,
                         input logic rs, input int hold, input bit poke,
                         output logic [W:0] res, output int lat);
    int n;
    @(posedge clk); #1;
    a = ra; b = rb; cin = rc; sub = rs; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_within_budget", {{W{1'b0}}, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = rnd_op(); b = rnd_op(); cin = ~rc; sub = ~rs;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (poke) in_valid = (lat == 1);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("out_valid_within_budget", {{W{1'b0}}, out_valid}, 1);
    res = {cout, sum};
    repeat (hold) begin
      @(posedge clk); #1;
    end
    chk("held_result", {cout, sum}, res);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0]   res, e;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_reset_idle", {{W{1'b0}}, in_ready, out_valid}, 2);

    // carry ripples through every limb
    run_req('1, 1, 1'b0, 1'b0, 0, 1'b0, res, lat);
    chk("ripple_result", res, {1'b1, {W{1'b0}}});
    chk("ripple_latency", lat, 4);

    // borrows
    run_req('0, 1, 1'b1, 1'b1, 0, 1'b0, res, lat);
    chk("borrow_0_minus_1", res, {1'b0, {W{1'b1}}});
    run_req(5, 3, 1'b0, 1'b1, 1, 1'b0, res, lat);
    chk("sub_5_minus_3", res, 2 | (1 << W));

    // limb boundary
    ra = '0; ra[63:0] = '1;
    run_req(ra, 0, 1'b1, 1'b0, 0, 1'b0, res, lat);
    e = '0; e[64] = 1'b1;
    chk("limb_boundary", res, e);

    // backpressure with in_valid pulsed mid-run
    run_req(100, 23, 1'b1, 1'b0, 5, 1'b1, res, lat);
    chk("backpressure_result", res, 124);
    chk("backpressure_latency", lat, 4);

    // reset at idx=2
    @(posedge clk); #1;
    a = '1; b = 1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    chk("mid_reset_ready", {{W{1'b0}}, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("mid_reset_async", {out_valid, sum}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_reset_idle", {{W{1'b0}}, in_ready, out_valid}, 2);
    chk("mid_reset_sum", {cout, sum}, 0);
    run_req(7, 9, 1'b1, 1'b0, 0, 1'b0, res, lat);
    chk("after_reset_result", res, 17);

    for (int i = 0; i < 1000; i++) begin
      ra = rnd_op(); rb = rnd_op();
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      run_req(ra, rb, rc, rs, $urandom_range(0, 2), 1'($urandom_range(0, 1)), res, lat);
      chk("rand_result", res, ref_result(ra, rb, rc, rs));
      chk("rand_latency", lat, LIMBS);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
